// File: rtl/nvdla_tcdm_rr_arbiter.sv
// nvdla_tcdm_rr_arbiter
// Shares one TCDM master port among NP streamer ports. Each request goes to a
// round-robin winner. Responses come back in order and are steered to their
// requesters by an ID FIFO.
// Optional feature: define NVDLA_ARB_STALL_CNT_EN to build the saturating stall
// counter on stall_cnt_o. Without it, stall_cnt_o is tied to zero.
module nvdla_tcdm_rr_arbiter #(
    parameter int NP = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int OD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [NP-1:0]        in_req_i,
    output logic [NP-1:0]        in_gnt_o,
    input  logic [NP*AW-1:0]     in_add_i,
    input  logic [NP-1:0]        in_wen_i,
    input  logic [NP*DW/8-1:0]   in_be_i,
    input  logic [NP*DW-1:0]     in_data_i,
    output logic [NP*DW-1:0]     in_r_data_o,
    output logic [NP-1:0]        in_r_valid_o,
    output logic                 out_req_o,
    input  logic                 out_gnt_i,
    output logic [AW-1:0]        out_add_o,
    output logic                 out_wen_o,
    output logic [DW/8-1:0]      out_be_o,
    output logic [DW-1:0]        out_data_o,
    input  logic [DW-1:0]        out_r_data_i,
    input  logic                 out_r_valid_i,
    output logic [$clog2(OD):0]  outstanding_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [15:0]          stall_cnt_o
);

    localparam int IW  = $clog2(NP);
    localparam int FAW = $clog2(OD);
    localparam int CW  = FAW + 1;
    localparam int BW  = DW / 8;

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  winner;
    logic           found;
    logic [IW-1:0]  cand;
    logic [IW-1:0]  id_mem [OD];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  head_id;
    logic           fifo_full;
    logic           fifo_empty;
    logic           handshake;
    logic           pop;

    assign fifo_full  = (count == CW'(OD));
    assign fifo_empty = (count == '0);
    assign head_id    = id_mem[rd_ptr];

    // Pick the first requesting port, scanning from ptr and wrapping modulo NP.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = ptr;
        for (int unsigned i = 0; i < NP; i++) begin
            if (!found && in_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = (cand == IW'(NP - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign out_req_o = !rst_i && enable_i && (|in_req_i) && !fifo_full;
    assign handshake = out_req_o && out_gnt_i;
    assign pop       = !rst_i && out_r_valid_i && !fifo_empty;

    // Pass the winner's payload through. Drive zeros when nothing is requested.
    always_comb begin
        out_add_o  = '0;
        out_wen_o  = 1'b0;
        out_be_o   = '0;
        out_data_o = '0;
        if (out_req_o) begin
            out_add_o  = in_add_i[int'(winner) * AW +: AW];
            out_wen_o  = in_wen_i[winner];
            out_be_o   = in_be_i[int'(winner) * BW +: BW];
            out_data_o = in_data_i[int'(winner) * DW +: DW];
        end
    end

    // Grant only the winner. Route a response to the port at the FIFO head.
    always_comb begin
        in_gnt_o     = '0;
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            in_gnt_o[p] = handshake && (winner == IW'(p));
            if (pop && (head_id == IW'(p))) begin
                in_r_valid_o[p]            = 1'b1;
                in_r_data_o[p * DW +: DW]  = out_r_data_i;
            end
        end
    end

    // Record the granted port ID. The storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_mem[wr_ptr] <= winner;
        end
    end

    // Arbitration pointer, ID FIFO pointers, occupancy and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else if (clear_i) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (handshake) begin
                ptr    <= (winner == IW'(NP - 1)) ? '0 : winner + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (handshake && !pop) begin
                count <= count + 1'b1;
            end else if (!handshake && pop) begin
                count <= count - 1'b1;
            end
            if (out_r_valid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;
    assign busy_o        = !fifo_empty;

`ifdef NVDLA_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Count the cycles in which a request is presented but not granted. Saturates at 16'hFFFF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (clear_i) begin
            stall_cnt <= '0;
        end else if (out_req_o && !out_gnt_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
